// File: rtl/ast_dmx_pkg.sv
// Shared types and default parameters for the packet demultiplexer.
package ast_dmx_pkg;

  localparam int DATA_W_D     = 64;
  localparam int CHANNEL_W_D  = 8;
  localparam int TX_DIR_D     = 4;
  localparam int FIFO_DEPTH_D = 8;
  localparam int CNT_W_D      = 16;

  // $clog2 with a floor of 1 so degenerate widths never collapse to zero bits
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int EMPTY_W_D = clog2_min1(DATA_W_D / 8);

  // Beat layout at the default widths; the top builds the same layout at its own widths
  typedef struct packed {
    logic [DATA_W_D-1:0]    data;
    logic [EMPTY_W_D-1:0]   empty;
    logic [CHANNEL_W_D-1:0] channel;
    logic                   sop;
    logic                   eop;
  } beat_t;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

endpackage

// File: rtl/ast_dmx_buf_if.sv
// Sink and per-direction source signals of the demultiplexer.
interface ast_dmx_buf_if #(
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHANNEL_W = 8,
  parameter int TX_DIR    = 4,
  parameter int DIR_SEL_W = 2
) ();

  logic [DIR_SEL_W-1:0]              dir_i;
  logic [DATA_W-1:0]                 ast_data_i;
  logic                              ast_startofpacket_i;
  logic                              ast_endofpacket_i;
  logic                              ast_valid_i;
  logic [EMPTY_W-1:0]                ast_empty_i;
  logic [CHANNEL_W-1:0]              ast_channel_i;
  logic                              ast_ready_o;
  logic [TX_DIR-1:0][DATA_W-1:0]     ast_data_o;
  logic [TX_DIR-1:0]                 ast_startofpacket_o;
  logic [TX_DIR-1:0]                 ast_endofpacket_o;
  logic [TX_DIR-1:0]                 ast_valid_o;
  logic [TX_DIR-1:0][EMPTY_W-1:0]    ast_empty_o;
  logic [TX_DIR-1:0][CHANNEL_W-1:0]  ast_channel_o;
  logic [TX_DIR-1:0]                 ast_ready_i;

  // Upstream source plus downstream sinks
  modport master (
    output dir_i, ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
           ast_empty_i, ast_channel_i, ast_ready_i,
    input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
           ast_valid_o, ast_empty_o, ast_channel_o
  );

  // The demultiplexer itself
  modport slave (
    input  dir_i, ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
           ast_empty_i, ast_channel_i, ast_ready_i,
    output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
           ast_valid_o, ast_empty_o, ast_channel_o
  );

endinterface

// File: rtl/ast_dmx_fifo.sv
// First-word-fall-through FIFO; head entry is read straight from storage registers.
module ast_dmx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_wr, do_rd;

  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  // Extra pointer bit tells full from empty when the index bits match
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  // Pointer update; pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ast_dmx_buf.sv
// Packet-granular Avalon-ST demultiplexer with one FIFO per output direction.
module ast_dmx_buf
  import ast_dmx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_D,
  parameter int EMPTY_W    = clog2_min1(DATA_W / 8),
  parameter int CHANNEL_W  = CHANNEL_W_D,
  parameter int TX_DIR     = TX_DIR_D,
  parameter int DIR_SEL_W  = clog2_min1(TX_DIR),
  parameter int FIFO_DEPTH = FIFO_DEPTH_D,
  parameter int CNT_W      = CNT_W_D
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  ast_dmx_buf_if.slave     bus,
  output logic [CNT_W-1:0] drop_pkt_cnt_o,
  output logic [CNT_W-1:0] orphan_cnt_o
);

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [EMPTY_W-1:0]   empty;
    logic [CHANNEL_W-1:0] channel;
    logic                 sop;
    logic                 eop;
  } lane_beat_t;

  localparam int BW = $bits(lane_beat_t);

  state_t                   state, state_nxt;
  logic [DIR_SEL_W-1:0]     dir_q, wr_dir;
  logic [TX_DIR-1:0]        full, empty, wr, rd;
  lane_beat_t               wbeat;
  lane_beat_t [TX_DIR-1:0]  rbeat;
  logic                     acc, sop, eop, legal, all_room, ready, fwd_beat, drop_inc, orph_inc;

  assign sop      = bus.ast_startofpacket_i;
  assign eop      = bus.ast_endofpacket_i;
  assign legal    = int'(bus.dir_i) < TX_DIR;
  assign all_room = ~|full;
  assign acc      = bus.ast_valid_i & ready;
  assign wbeat    = '{data: bus.ast_data_i, empty: bus.ast_empty_i,
                      channel: bus.ast_channel_i, sop: sop, eop: eop};

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Direction latch, loaded only by an accepted SOP with a legal direction
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                dir_q <= '0;
    else if (acc & sop & legal)  dir_q <= bus.dir_i;
  end

  // Next state: any SOP restarts packet tracking, EOP closes it
  always_comb begin
    state_nxt = state;
    if (acc) begin
      if (sop)                      state_nxt = eop ? IDLE : (legal ? FWD : DROP);
      else if (state != IDLE && eop) state_nxt = IDLE;
    end
  end

  // Outputs: ready, write target and counter strobes.
  // A mid-packet SOP may retarget any FIFO, so it also needs room everywhere.
  always_comb begin
    ready    = 1'b0;
    wr_dir   = dir_q;
    fwd_beat = (state == FWD);
    case (state)
      IDLE:    ready = all_room;
      FWD:     ready = ~full[dir_q] & (~sop | all_room);
      DROP:    ready = ~sop | all_room;
      default: ready = 1'b0;
    endcase
    if (sop) begin
      wr_dir   = bus.dir_i;
      fwd_beat = legal;
    end
    ready    = ready & rst_n_i;
    drop_inc = acc & sop & ~legal;
    orph_inc = acc & ~sop & (state == IDLE);
  end

  // Saturating statistics counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_pkt_cnt_o <= '0;
      orphan_cnt_o   <= '0;
    end else begin
      if (drop_inc && drop_pkt_cnt_o != '1) drop_pkt_cnt_o <= drop_pkt_cnt_o + 1'b1;
      if (orph_inc && orphan_cnt_o != '1)   orphan_cnt_o   <= orphan_cnt_o + 1'b1;
    end
  end

  for (genvar k = 0; k < TX_DIR; k++) begin : g_lane
    assign wr[k] = acc & fwd_beat & (int'(wr_dir) == k);
    assign rd[k] = ~empty[k] & bus.ast_ready_i[k];

    ast_dmx_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .wr    (wr[k]),
      .wdata (wbeat),
      .rd    (rd[k]),
      .rdata (rbeat[k]),
      .full  (full[k]),
      .empty (empty[k])
    );

    assign bus.ast_data_o[k]          = rbeat[k].data;
    assign bus.ast_empty_o[k]         = rbeat[k].empty;
    assign bus.ast_channel_o[k]       = rbeat[k].channel;
    assign bus.ast_startofpacket_o[k] = rbeat[k].sop;
    assign bus.ast_endofpacket_o[k]   = rbeat[k].eop;
  end

  assign bus.ast_valid_o = ~empty;
  assign bus.ast_ready_o = ready;

endmodule

// File: tb/tb_ast_dmx_buf.sv
// Directed bench for ast_dmx_buf with three directions and 8-deep FIFOs.
module tb_ast_dmx_buf;

  localparam int DATA_W = 32, EMPTY_W = 2, CHANNEL_W = 8, TX_DIR = 3;
  localparam int DIR_SEL_W = 2, FIFO_DEPTH = 8, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] drop_cnt, orph_cnt;
  int               tests = 0, fails = 0;

  always #5 clk = ~clk;

  ast_dmx_buf_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CHANNEL_W(CHANNEL_W),
                   .TX_DIR(TX_DIR), .DIR_SEL_W(DIR_SEL_W)) bus ();

  ast_dmx_buf #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CHANNEL_W(CHANNEL_W), .TX_DIR(TX_DIR),
                .DIR_SEL_W(DIR_SEL_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .bus            (bus),
    .drop_pkt_cnt_o (drop_cnt),
    .orphan_cnt_o   (orph_cnt)
  );

  task automatic drive(input logic v, input logic s, input logic e, input logic [1:0] d,
                       input logic [31:0] dat, input logic [1:0] emp, input logic [7:0] ch);
    bus.ast_valid_i         = v;
    bus.ast_startofpacket_i = s;
    bus.ast_endofpacket_i   = e;
    bus.dir_i               = d;
    bus.ast_data_i          = dat;
    bus.ast_empty_i         = emp;
    bus.ast_channel_i       = ch;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 2'd0, 8'h0);
  endtask

  task automatic test_reset();
    idle();
    bus.ast_ready_i = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.ast_valid_o !== 3'b000) begin fails++; $display("FAIL reset_valid got=%b exp=000", bus.ast_valid_o); end
    tests++; if (bus.ast_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", bus.ast_ready_o); end
    tests++; if (drop_cnt !== 16'd0 || orph_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", drop_cnt, orph_cnt); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    tests++; if (bus.ast_ready_o !== 1'b1) begin fails++; $display("FAIL idle_ready got=%b exp=1", bus.ast_ready_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_fwd3();
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive(1'b1, i == 0, i == 2, 2'd2, 32'hA000_0000 + i, 2'(i), 8'h40 + 8'(i));
      else       idle();
      @(negedge clk);
      if (i == 0) begin
        tests++; if (bus.ast_valid_o !== 3'b000) begin fails++; $display("FAIL fwd3_pre_valid got=%b exp=000", bus.ast_valid_o); end
      end else begin
        tests++; if (bus.ast_valid_o !== 3'b100) begin fails++; $display("FAIL fwd3_valid[%0d] got=%b exp=100", i, bus.ast_valid_o); end
        tests++; if (bus.ast_data_o[2] !== 32'hA000_0000 + i - 1) begin fails++; $display("FAIL fwd3_data[%0d] got=%h exp=%h", i, bus.ast_data_o[2], 32'hA000_0000 + i - 1); end
        tests++; if (bus.ast_channel_o[2] !== 8'h40 + 8'(i - 1) || bus.ast_empty_o[2] !== 2'(i - 1)) begin fails++; $display("FAIL fwd3_chan_empty[%0d] got=%h/%0d", i, bus.ast_channel_o[2], bus.ast_empty_o[2]); end
        tests++; if (bus.ast_startofpacket_o[2] !== (i == 1) || bus.ast_endofpacket_o[2] !== (i == 3)) begin fails++; $display("FAIL fwd3_sop_eop[%0d] got=%b%b", i, bus.ast_startofpacket_o[2], bus.ast_endofpacket_o[2]); end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++; if (bus.ast_valid_o !== 3'b000) begin fails++; $display("FAIL fwd3_post_valid got=%b exp=000", bus.ast_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_drop();
    drive(1'b1, 1'b1, 1'b1, 2'd3, 32'hDEAD_BEEF, 2'd0, 8'h01);
    @(negedge clk);
    tests++; if (bus.ast_ready_o !== 1'b1) begin fails++; $display("FAIL drop_ready got=%b exp=1", bus.ast_ready_o); end
    @(posedge clk); #1 idle();
    @(negedge clk);
    tests++; if (bus.ast_valid_o !== 3'b000) begin fails++; $display("FAIL drop_valid got=%b exp=000", bus.ast_valid_o); end
    tests++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
    @(posedge clk); #1;
  endtask

  // Orphan counting also shows the FSM returned to IDLE after the dropped packet
  task automatic test_orphan();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0BAD_0001, 2'd0, 8'h02);
    @(posedge clk); #1 idle();
    @(negedge clk);
    tests++; if (orph_cnt !== 16'd1) begin fails++; $display("FAIL orphan_cnt got=%0d exp=1", orph_cnt); end
    tests++; if (bus.ast_valid_o !== 3'b000) begin fails++; $display("FAIL orphan_valid got=%b exp=000", bus.ast_valid_o); end
    tests++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL orphan_drop_cnt got=%0d exp=1", drop_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int  i = 0, j = 0;
    logic acc;
    bus.ast_ready_i = 3'b101;
    for (int c = 0; c < 12; c++) begin
      if (i < 10) drive(1'b1, i == 0, i == 9, 2'd1, 32'hB000 + i, 2'd0, 8'h11);
      else        idle();
      @(negedge clk); acc = bus.ast_valid_i & bus.ast_ready_o;
      @(posedge clk); if (acc) i++;
      #1;
    end
    @(negedge clk);
    tests++; if (i !== 8) begin fails++; $display("FAIL bp_accepted got=%0d exp=8", i); end
    tests++; if (bus.ast_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready got=%b exp=0", bus.ast_ready_o); end
    @(posedge clk); #1;
    // A new packet to dir 0 must wait until dir 1's packet closes
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b1, 2'd0, 32'hC0C0, 2'd0, 8'h12);
      @(negedge clk);
      tests++; if (bus.ast_ready_o !== 1'b0 || bus.ast_valid_o[0] !== 1'b0) begin fails++; $display("FAIL bp_block[%0d] got ready=%b v0=%b exp=0/0", c, bus.ast_ready_o, bus.ast_valid_o[0]); end
      @(posedge clk); #1;
    end
    bus.ast_ready_i = 3'b111;
    for (int c = 0; c < 16; c++) begin
      if (i < 10) drive(1'b1, 1'b0, i == 9, 2'd1, 32'hB000 + i, 2'd0, 8'h11);
      else        idle();
      @(negedge clk); acc = bus.ast_valid_i & bus.ast_ready_o;
      if (bus.ast_valid_o[1]) begin
        tests++; if (bus.ast_data_o[1] !== 32'hB000 + j || bus.ast_startofpacket_o[1] !== (j == 0) || bus.ast_endofpacket_o[1] !== (j == 9)) begin
          fails++; $display("FAIL bp_drain[%0d] got=%h sop=%b eop=%b exp=%h", j, bus.ast_data_o[1], bus.ast_startofpacket_o[1], bus.ast_endofpacket_o[1], 32'hB000 + j);
        end
        j++;
      end
      @(posedge clk); if (acc) i++;
      #1;
    end
    @(negedge clk);
    tests++; if (j !== 10 || i !== 10) begin fails++; $display("FAIL bp_drain_count got=%0d/%0d exp=10/10", j, i); end
    tests++; if (bus.ast_valid_o !== 3'b000) begin fails++; $display("FAIL bp_final_valid got=%b exp=000", bus.ast_valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_dir_toggle();
    logic [1:0] dseq [4] = '{2'd0, 2'd1, 2'd2, 2'd1};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(1'b1, i == 0, i == 3, dseq[i], 32'hC000 + i, 2'd0, 8'h22);
      else       idle();
      @(negedge clk);
      if (i > 0) begin
        tests++; if (bus.ast_valid_o !== 3'b001 || bus.ast_data_o[0] !== 32'hC000 + i - 1) begin
          fails++; $display("FAIL toggle[%0d] got valid=%b data=%h exp=001/%h", i, bus.ast_valid_o, bus.ast_data_o[0], 32'hC000 + i - 1);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    bus.ast_ready_i = 3'b101;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, 1'b0, 2'd1, 32'hE000 + i, 2'd0, 8'h33);
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    tests++; if (bus.ast_valid_o !== 3'b010) begin fails++; $display("FAIL rmid_pre_valid got=%b exp=010", bus.ast_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.ast_valid_o !== 3'b000 || bus.ast_ready_o !== 1'b0) begin fails++; $display("FAIL rmid_async got valid=%b ready=%b exp=000/0", bus.ast_valid_o, bus.ast_ready_o); end
    tests++; if (drop_cnt !== 16'd0 || orph_cnt !== 16'd0) begin fails++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", drop_cnt, orph_cnt); end
    @(posedge clk); #1 rst_n = 1'b1;
    bus.ast_ready_i = 3'b111;
    drive(1'b1, 1'b1, 1'b1, 2'd2, 32'hD00D, 2'd1, 8'h44);
    @(posedge clk); #1 idle();
    @(negedge clk);
    tests++; if (bus.ast_valid_o !== 3'b100 || bus.ast_data_o[2] !== 32'hD00D) begin fails++; $display("FAIL rmid_route got valid=%b data=%h exp=100/d00d", bus.ast_valid_o, bus.ast_data_o[2]); end
    tests++; if (bus.ast_startofpacket_o[2] !== 1'b1 || bus.ast_endofpacket_o[2] !== 1'b1 || bus.ast_channel_o[2] !== 8'h44) begin fails++; $display("FAIL rmid_fields got sop=%b eop=%b ch=%h", bus.ast_startofpacket_o[2], bus.ast_endofpacket_o[2], bus.ast_channel_o[2]); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_fwd3();
    test_drop();
    test_orphan();
    test_backpressure();
    test_dir_toggle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
